// File: rtl/prince_cms_pkg.sv
// Shared constants and types for the PRINCE CMS masked datapath.
// Widths of the nibble/state and the share counts on each side of compression.
package prince_cms_pkg;

  localparam int NIBBLE_W       = 4;
  localparam int STATE_W        = 64;
  localparam int NUM_EXP_SHARES = 4;
  localparam int NUM_CMP_SHARES = 2;

  typedef logic [STATE_W-1:0] share_t;

endpackage

// File: rtl/share_refresh_reg.sv
// One refresh register bank: XOR a share with its mask and hold the result.
// Loads only on enable so the stored masked share never toggles spuriously.
module share_refresh_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] share_i,
  input  logic [W-1:0] mask_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  assign q_d = share_i ^ mask_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/prince_share_compress.sv
// Two-stage share compression: refresh 4 expanded shares with fresh masks,
// register, then fold pairs into 2 output shares. Valid/ready pipelined.
module prince_share_compress
  import prince_cms_pkg::*;
#(
  parameter  int NIBBLES = 16,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s0,
  input  logic [W-1:0] s1,
  input  logic [W-1:0] s2,
  input  logic [W-1:0] s3,
  input  logic [W-1:0] r0,
  input  logic [W-1:0] r1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c0,
  output logic [W-1:0] c1
);

  logic         v1_q, v1_d;
  logic         v2_q, v2_d;
  logic         fire_in, adv1, adv2;
  logic [W-1:0] t0, t1, t2, t3;
  logic [W-1:0] c0_q, c0_d;
  logic [W-1:0] c1_q, c1_d;

  always_comb begin
    adv2     = v2_q & out_ready;
    adv1     = v1_q & (~v2_q | adv2);
    in_ready = ~v1_q | adv1;
    fire_in  = in_valid & in_ready;
    v1_d     = fire_in | (v1_q & ~adv1);
    v2_d     = adv1 | (v2_q & ~out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  // Stage 1: each share is masked on its own; no share meets another share here.
  share_refresh_reg #(.W(W)) u_t0 (
    .clk(clk), .rst_n(rst_n), .en_i(fire_in), .share_i(s0), .mask_i(r0), .q_o(t0)
  );
  share_refresh_reg #(.W(W)) u_t1 (
    .clk(clk), .rst_n(rst_n), .en_i(fire_in), .share_i(s1), .mask_i(r1), .q_o(t1)
  );
  share_refresh_reg #(.W(W)) u_t2 (
    .clk(clk), .rst_n(rst_n), .en_i(fire_in), .share_i(s2), .mask_i(r0), .q_o(t2)
  );
  share_refresh_reg #(.W(W)) u_t3 (
    .clk(clk), .rst_n(rst_n), .en_i(fire_in), .share_i(s3), .mask_i(r1), .q_o(t3)
  );

  // Stage 2: combine only registered, masked values; r0/r1 cancel in c0^c1.
  always_comb begin
    c0_d = t0 ^ t1;
    c1_d = t2 ^ t3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c0_q <= '0;
      c1_q <= '0;
    end else if (adv1) begin
      c0_q <= c0_d;
      c1_q <= c1_d;
    end
  end

  assign out_valid = v2_q;
  assign c0        = c0_q;
  assign c1        = c1_q;

endmodule

// File: tb/tb_prince_share_compress.sv
// Directed and random bench for prince_share_compress with a queue scoreboard.
module tb_prince_share_compress;

  localparam int NIB = 1;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0, r0 = '0, r1 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] c0, c1;

  always #5 clk = ~clk;

  prince_share_compress #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .r0(r0), .r1(r1),
    .out_valid(out_valid), .out_ready(out_ready), .c0(c0), .c1(c1)
  );

  typedef struct {
    logic [W-1:0] c0;
    logic [W-1:0] c1;
    logic [W-1:0] x;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_out = 0;
  bit lat_chk = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called with clk low and inputs already driven; samples, then crosses one rising edge.
  task automatic cycle(output bit fired);
    exp_t e;
    #1;
    fired = 1'b0;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("c0", 64'(c0), 64'(e.c0));
        check("c1", 64'(c1), 64'(e.c1));
        check("invariant", 64'(c0 ^ c1), 64'(e.x));
        if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'd2);
      end
      n_out++;
    end
    if (in_valid && in_ready) begin
      e.c0  = s0 ^ r0 ^ s1 ^ r1;
      e.c1  = s2 ^ r0 ^ s3 ^ r1;
      e.x   = s0 ^ s1 ^ s2 ^ s3;
      e.cyc = cyc;
      sb.push_back(e);
      fired = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input logic [W-1:0] a, b, c, d, m0, m1);
    s0 = a; s1 = b; s2 = c; s3 = d; r0 = m0; r1 = m1;
  endtask

  task automatic drain(input int budget);
    bit f;
    in_valid = 1'b0;
    for (int i = 0; i < budget && sb.size() != 0; i++) cycle(f);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    bit f;
    logic [W-1:0] hold_c0, hold_c1, t0_prev;
    int out_base;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_c0", 64'(c0), 64'd0);
    check("rst_c1", 64'(c1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vector 1
    lat_chk = 1'b1;
    out_ready = 1'b1;
    drive(4'hA, 4'h3, 4'h5, 4'h0, 4'h6, 4'h9);
    in_valid = 1'b1;
    cycle(f);
    in_valid = 1'b0;
    #1 check("v1_not_early", 64'(out_valid), 64'd0);
    cycle(f);
    drain(4);
    check("v1_c0_const", 64'(c0), 64'h6);
    check("v1_c1_const", 64'(c1), 64'hA);

    // Directed vector 2
    drive(4'hA, 4'h3, 4'h5, 4'hC, 4'h6, 4'h9);
    in_valid = 1'b1;
    cycle(f);
    drain(4);
    check("v2_c0_const", 64'(c0), 64'h6);
    check("v2_c1_const", 64'(c1), 64'h6);

    // 1000 random masks and shares, streamed
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      drive(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            4'($urandom), 4'($urandom));
      cycle(f);
    end
    drain(6);

    // Backpressure: three inputs against a stalled output
    lat_chk = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5);
    cycle(f);
    check("bp_acc1", 64'(f), 64'd1);
    drive(4'h7, 4'hE, 4'h0, 4'h9, 4'hC, 4'h1);
    cycle(f);
    check("bp_acc2", 64'(f), 64'd1);
    drive(4'hF, 4'h4, 4'hB, 4'h2, 4'h8, 4'h6);
    #1;
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    hold_c0 = c0;
    hold_c1 = c1;
    cycle(f);
    check("bp_no_accept", 64'(f), 64'd0);
    #1;
    check("bp_hold_c0", 64'(c0), 64'(hold_c0));
    check("bp_hold_c1", 64'(c1), 64'(hold_c1));
    check("bp_in_ready_still_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    f = 1'b0;
    for (int i = 0; i < 8 && !f; i++) cycle(f);
    check("bp_acc3", 64'(f), 64'd1);
    drain(8);

    // Streaming 20 with incrementing s0
    lat_chk = 1'b1;
    out_base = n_out;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(4'(i), 4'h3, 4'h5, 4'hA, 4'($urandom), 4'($urandom));
      cycle(f);
    end
    drain(6);
    check("stream_count", 64'(n_out - out_base), 64'd20);

    // r0 changes while idle must not reach the t-registers
    t0_prev = dut.t0;
    in_valid = 1'b0;
    r0 = ~r0;
    cycle(f);
    check("idle_t0_hold", 64'(dut.t0), 64'(t0_prev));
    drive(4'h3, 4'h1, 4'h2, 4'h4, 4'h5, 4'h7);
    in_valid = 1'b1;
    cycle(f);
    in_valid = 1'b0;
    r0 = 4'hF;
    check("t0_capture", 64'(dut.t0), 64'h6);
    cycle(f);
    check("t0_after_r0_change", 64'(dut.t0), 64'h6);
    drain(4);

    // Async reset with both stages full
    lat_chk = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4);
    cycle(f);
    drive(4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3);
    cycle(f);
    in_valid = 1'b0;
    #1 check("pre_rst_ov", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_c0", 64'(c0), 64'd0);
    check("arst_c1", 64'(c1), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 check("post_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      #1 check("post_rst_no_stale", 64'(out_valid), 64'd0);
      cycle(f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed run still active expected finish");
    $fatal(1);
  end

endmodule
